// File: rtl/fpu_addsub_ctrl_if.sv
// Upstream operation and downstream result handshakes of the fadd controller.
interface fpu_addsub_ctrl_if #(
  parameter int unsigned TAGW = 5
) ();

  // Upstream: operation offer
  logic            in_valid;
  logic            in_ready;
  logic            in_op;
  logic [31:0]     in_x1;
  logic [31:0]     in_x2;
  logic [TAGW-1:0] in_tag;

  // Downstream: result delivery
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_y;
  logic            out_ovf;
  logic [TAGW-1:0] out_tag;

  // Producer of operations / consumer of results
  modport master (
    output in_valid, in_op, in_x1, in_x2, in_tag, out_ready,
    input  in_ready, out_valid, out_y, out_ovf, out_tag
  );

  // The controller itself
  modport slave (
    input  in_valid, in_op, in_x1, in_x2, in_tag, out_ready,
    output in_ready, out_valid, out_y, out_ovf, out_tag
  );

endinterface

// File: rtl/fpu_addsub_ctrl.sv
// Credit-based wrapper around a fixed-latency fadd: issues add/sub operands,
// tracks results through a LAT-deep valid/tag pipe and queues them in a
// DEPTH-entry FIFO so results leave in accept order without loss.
module fpu_addsub_ctrl #(
  parameter int unsigned LAT   = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAGW  = 5
) (
  input  logic               clk,
  input  logic               rstn,
  fpu_addsub_ctrl_if.slave   s_if,
  output logic [31:0]        fa_x1,
  output logic [31:0]        fa_x2,
  input  logic [31:0]        fa_y,
  input  logic               fa_ovf,
  input  logic               clr,
  output logic               ovf_sticky,
  output logic               busy
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [31:0]     y;
    logic            ovf;
    logic [TAGW-1:0] tag;
  } entry_t;

  // Handshake qualifiers
  logic accept_c;
  logic pop_c;
  logic wr_c;

  // Issue pipe tracking operations inside the fadd
  logic [LAT-1:0]  vld_q, vld_d;
  logic [TAGW-1:0] tag_q [LAT];
  logic [TAGW-1:0] tag_d [LAT];

  // Result FIFO
  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   fcnt_q, fcnt_d;

  // Registered head of the FIFO as seen downstream
  logic            out_vld_q, out_vld_d;
  entry_t          head_q, head_d;

  // Credits and status
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rdy_q, rdy_d;
  logic            busy_q, busy_d;
  logic            sticky_q, sticky_d;

  // Pointer advance with wrap at DEPTH (DEPTH need not be a power of two)
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // in_ready depends only on credit state and reset, never on in_valid/out_ready
  assign s_if.in_ready = rdy_q & rstn;

  // Handshake decode
  always_comb begin
    accept_c = s_if.in_valid & s_if.in_ready;
    pop_c    = out_vld_q & s_if.out_ready;
    wr_c     = vld_q[LAT-1];
  end

  // Operand steering to the fadd: sub flips the sign of x2, idle drives zeros
  always_comb begin
    fa_x1 = '0;
    fa_x2 = '0;
    if (accept_c) begin
      fa_x1 = s_if.in_x1;
      fa_x2 = s_if.in_op ? {~s_if.in_x2[31], s_if.in_x2[30:0]} : s_if.in_x2;
    end
  end

  // Valid and tag shift pipes aligned with the fadd latency
  always_comb begin
    vld_d    = '0;
    vld_d[0] = accept_c;
    for (int unsigned i = 0; i < LAT; i++) begin
      tag_d[i] = tag_q[i];
    end
    tag_d[0] = s_if.in_tag;
    for (int unsigned i = 1; i < LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      tag_d[i] = tag_q[i-1];
    end
  end

  // FIFO write/pop and next head; the head is taken from next-state storage
  // so a write into an empty FIFO shows up one cycle later (no bypass)
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fcnt_d   = fcnt_q;
    if (wr_c) begin
      mem_d[wr_ptr_q] = '{y: fa_y, ovf: fa_ovf, tag: tag_q[LAT-1]};
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop_c) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({wr_c, pop_c})
      2'b10:   fcnt_d = fcnt_q + CW'(1);
      2'b01:   fcnt_d = fcnt_q - CW'(1);
      default: fcnt_d = fcnt_q;
    endcase
    out_vld_d = (fcnt_d != '0);
    head_d    = out_vld_d ? mem_d[rd_ptr_d] : '0;
  end

  // Credits cover in-flight plus queued results, which bounds FIFO occupancy
  always_comb begin
    case ({accept_c, pop_c})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    rdy_d    = (cnt_d < CW'(DEPTH));
    busy_d   = (cnt_d != '0);
    // A new overflow write wins over a coincident clear
    sticky_d = (wr_c & fa_ovf) | (sticky_q & ~clr);
  end

  // Control state with synchronous reset; discards all in-flight/queued ops
  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fcnt_q    <= '0;
      out_vld_q <= 1'b0;
      head_q    <= '0;
      cnt_q     <= '0;
      rdy_q     <= 1'b1;
      busy_q    <= 1'b0;
      sticky_q  <= 1'b0;
    end else begin
      vld_q     <= vld_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fcnt_q    <= fcnt_d;
      out_vld_q <= out_vld_d;
      head_q    <= head_d;
      cnt_q     <= cnt_d;
      rdy_q     <= rdy_d;
      busy_q    <= busy_d;
      sticky_q  <= sticky_d;
    end
  end

  // Data storage without reset; validity is carried by the control state
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < LAT; i++) begin
      tag_q[i] <= tag_d[i];
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  assign s_if.out_valid = out_vld_q;
  assign s_if.out_y     = head_q.y;
  assign s_if.out_ovf   = head_q.ovf;
  assign s_if.out_tag   = head_q.tag;
  assign ovf_sticky     = sticky_q;
  assign busy           = busy_q;

endmodule
